// File: rtl/simplez_io_uart_if.sv
// CPU-side bus of the SIMPLEZ I/O window: address, write strobe, write data,
// plus the select and read-data path back to the CPU data-bus mux.
interface simplez_io_uart_if #(
  parameter int unsigned DATAW = 12,
  parameter int unsigned ADDRW = 9
);
  logic [ADDRW-1:0] addr;
  logic             wr;
  logic [DATAW-1:0] data_in;
  logic             sel;
  logic [DATAW-1:0] data_out;

  modport master (output addr, wr, data_in, input sel, data_out);
  modport slave  (input addr, wr, data_in, output sel, data_out);
endinterface

// File: rtl/simplez_io_uart.sv
// SIMPLEZ memory-mapped I/O: LED register plus 8N1 UART transmitter in a 4-word window.
// Define SIMPLEZ_IO_TXFIFO_EN for a 4-entry transmit FIFO instead of the single holding register.
module simplez_io_uart #(
  parameter int unsigned DATAW    = 12,
  parameter int unsigned ADDRW    = 9,
  parameter int unsigned BASE     = 508,
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  simplez_io_uart_if.slave     bus,
  output logic [3:0]           leds,
  output logic                 tx
);
  localparam int unsigned    CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_TOP = CW'(BAUD_DIV - 1);
  localparam logic [ADDRW:0] WIN_LO   = (ADDRW+1)'(BASE);
  localparam logic [ADDRW:0] WIN_HI   = (ADDRW+1)'(BASE + 3);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_baud, w_baud_d;
  logic [2:0]      r_bit, w_bit_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_tx, w_tx_d;
  logic [3:0]      r_leds;
  logic            r_ovr;

  logic [ADDRW:0]  w_addr_x, w_diff;
  logic [1:0]      w_off;
  logic            w_sel, w_wr_led, w_wr_stat, w_wr_tx;
  logic            w_ready, w_has, w_push, w_drop, w_pop, w_busy;
  logic [7:0]      w_byte, w_head;
  logic            w_baud_zero, w_last_bit;
  logic            w_unused_bits;

  // Widened by one bit so BASE+3 at the top of the address space cannot wrap
  assign w_addr_x  = {1'b0, bus.addr};
  assign w_diff    = w_addr_x - WIN_LO;
  assign w_off     = w_diff[1:0];
  assign w_sel     = (w_addr_x >= WIN_LO) && (w_addr_x <= WIN_HI);
  assign w_wr_led  = bus.wr & w_sel & (w_off == 2'd0);
  assign w_wr_stat = bus.wr & w_sel & (w_off == 2'd1);
  assign w_wr_tx   = bus.wr & w_sel & (w_off == 2'd2);
  assign w_byte    = bus.data_in[7:0];
  assign w_push    = w_wr_tx & w_ready;
  assign w_drop    = w_wr_tx & ~w_ready;
  assign w_unused_bits = ^{bus.data_in[DATAW-1:8], w_diff[ADDRW:2]};

`ifdef SIMPLEZ_IO_TXFIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;

  assign w_ready = (r_cnt != 3'd4);
  assign w_has   = (r_cnt != 3'd0);
  assign w_head  = r_fifo[r_rp];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_v;

  assign w_ready = ~r_hold_v;
  assign w_has   = r_hold_v;
  assign w_head  = r_hold;

  // Push needs an empty hold and pop needs a full one, so they never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (w_push) begin
      r_hold   <= w_byte;
      r_hold_v <= 1'b1;
    end else if (w_pop) begin
      r_hold_v <= 1'b0;
    end
  end
`endif

  assign w_baud_zero = (r_baud == '0);
  assign w_last_bit  = (r_bit == 3'd7);
  assign w_busy      = (r_state != S_IDLE) | w_has;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_has)                    w_state_nxt = S_START;
      S_START: if (w_baud_zero)              w_state_nxt = S_DATA;
      S_DATA:  if (w_baud_zero & w_last_bit) w_state_nxt = S_STOP;
      S_STOP:  if (w_baud_zero)              w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered: each branch computes the line level for the next cycle
  always_comb begin
    w_pop     = 1'b0;
    w_tx_d    = r_tx;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    case (r_state)
      S_IDLE: begin
        w_tx_d = 1'b1;
        if (w_has) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_tx_d    = 1'b0;
          w_baud_d  = BAUD_TOP;
        end
      end
      S_START: begin
        if (w_baud_zero) begin
          w_tx_d   = r_shift[0];
          w_baud_d = BAUD_TOP;
          w_bit_d  = '0;
        end else begin
          w_baud_d = r_baud - CW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_zero) begin
          w_baud_d = BAUD_TOP;
          if (w_last_bit) begin
            w_tx_d = 1'b1;
          end else begin
            w_tx_d    = r_shift[1];
            w_shift_d = {1'b0, r_shift[7:1]};
            w_bit_d   = r_bit + 3'd1;
          end
        end else begin
          w_baud_d = r_baud - CW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_zero) w_tx_d   = 1'b1;
        else             w_baud_d = r_baud - CW'(1);
      end
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_leds  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_tx    <= w_tx_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      if (w_wr_led)       r_leds <= bus.data_in[3:0];
      if (w_wr_stat)      r_ovr  <= 1'b0;
      else if (w_drop)    r_ovr  <= 1'b1;
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (w_sel) begin
      case (w_off)
        2'd0:    bus.data_out[3:0] = r_leds;
        2'd1:    bus.data_out[2:0] = {r_ovr, w_busy, w_ready};
        default: bus.data_out      = '0;
      endcase
    end
  end

  assign bus.sel = w_sel;
  assign leds    = r_leds;
  assign tx      = r_tx;
endmodule
